// File: rtl/exec_stage_md.sv
// Execute stage with a forwarding mux, a single-cycle ALU, an iterative radix-2
// multiply/divide unit and the EX/MEM pipeline register.
// ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
// MD ops (funct3): 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
module exec_stage_md #(
  parameter int XLEN  = 32,
  parameter bit MD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid,
  input  logic            is_md,
  input  logic [3:0]      alu_control,
  input  logic [2:0]      md_op,
  input  logic [1:0]      alu_src2,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] d1,
  input  logic [XLEN-1:0] d2,
  input  logic [XLEN-1:0] bp_mem,
  input  logic [XLEN-1:0] bp_wb,
  input  logic [1:0]      hu_rs1,
  input  logic [1:0]      hu_rs2,
  input  logic [4:0]      rd_in,
  input  logic            mem_we,
  input  logic            de_we,
  input  logic            mem_reg,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] wd_me,
  output logic [4:0]      rd,
  output logic            mem_we_me,
  output logic            me_we,
  output logic            mem_reg_me,
  output logic            md_busy
);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Operand signedness per funct3: rs1 is signed for MULH/MULHSU/DIV/REM,
  // rs2 only for MULH/DIV/REM.
  function automatic logic sgn_a(input logic [2:0] op);
    sgn_a = op[2] ? !op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
  endfunction

  function automatic logic sgn_b(input logic [2:0] op);
    sgn_b = op[2] ? !op[0] : (op[1:0] == 2'd1);
  endfunction

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [2*XLEN-1:0] p_q, p_d;     // {hi, lo}: product, or {remainder, quotient}
  logic [XLEN-1:0] m_q, m_d;       // multiplicand / divisor magnitude
  logic [XLEN-1:0] a_q, a_d;       // raw operands kept for the sign fix-up
  logic [XLEN-1:0] b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rdl_q, rdl_d;
  logic            wel_q, wel_d;

  logic [XLEN-1:0] alu_out_q, alu_out_d;
  logic [XLEN-1:0] wd_me_q, wd_me_d;
  logic [4:0]      rd_q, rd_d;
  logic            mem_we_me_q, mem_we_me_d;
  logic            me_we_q, me_we_d;
  logic            mem_reg_me_q, mem_reg_me_d;

  logic [XLEN-1:0] rs1v, rs2v, op_b, alu_res;
  logic [SW-1:0]   shamt;

  // Forwarding muxes; select 3 falls back to the register file value.
  always_comb begin
    case (hu_rs1)
      2'd1:    rs1v = bp_mem;
      2'd2:    rs1v = bp_wb;
      default: rs1v = d1;
    endcase
    case (hu_rs2)
      2'd1:    rs2v = bp_mem;
      2'd2:    rs2v = bp_wb;
      default: rs2v = d2;
    endcase
    op_b  = (alu_src2 == 2'd0) ? rs2v : imm;
    shamt = op_b[SW-1:0];
  end

  // Single-cycle ALU.
  always_comb begin
    alu_res = '0;
    case (alu_control)
      4'd0: alu_res = rs1v + op_b;
      4'd1: alu_res = rs1v - op_b;
      4'd2: alu_res = rs1v & op_b;
      4'd3: alu_res = rs1v | op_b;
      4'd4: alu_res = rs1v ^ op_b;
      4'd5: alu_res = rs1v << shamt;
      4'd6: alu_res = rs1v >> shamt;
      4'd7: alu_res = $signed(rs1v) >>> shamt;
      4'd8: alu_res = {{(XLEN-1){1'b0}}, $signed(rs1v) < $signed(op_b)};
      4'd9: alu_res = {{(XLEN-1){1'b0}}, rs1v < op_b};
      default: alu_res = '0;
    endcase
  end

  logic [XLEN:0]     mul_sum, div_rsh, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, prod_fix;
  logic [XLEN-1:0]   a_mag, b_mag, q_fix, r_fix, md_res;
  logic              a_neg, b_neg;

  // One radix-2 step of shift-add multiply / restoring divide, plus fix-up.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_next = {mul_sum, p_q[XLEN-1:1]};
    div_rsh  = {p_q[2*XLEN-1:XLEN], p_q[XLEN-1]};
    div_diff = div_rsh - {1'b0, m_q};
    div_next = div_diff[XLEN] ? {div_rsh[XLEN-1:0], p_q[XLEN-2:0], 1'b0}
                              : {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    a_mag    = (sgn_a(md_op) && rs1v[XLEN-1]) ? -rs1v : rs1v;
    b_mag    = (sgn_b(md_op) && rs2v[XLEN-1]) ? -rs2v : rs2v;
    a_neg    = sgn_a(op_q) & a_q[XLEN-1];
    b_neg    = sgn_b(op_q) & b_q[XLEN-1];
    prod_fix = (a_neg ^ b_neg) ? -p_q : p_q;
    q_fix    = (a_neg ^ b_neg) ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    r_fix    = a_neg ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    // A zero divisor bypasses the fix-up: all-ones quotient, dividend remainder.
    if (!op_q[2])
      md_res = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (b_q == '0)
      md_res = op_q[1] ? a_q : '1;
    else
      md_res = op_q[1] ? r_fix : q_fix;
  end

  // FSM next state and EX/MEM register load selection.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    m_d          = m_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rdl_d        = rdl_q;
    wel_d        = wel_q;
    alu_out_d    = alu_out_q;
    wd_me_d      = wd_me_q;
    rd_d         = rd_q;
    mem_we_me_d  = mem_we_me_q;
    me_we_d      = me_we_q;
    mem_reg_me_d = mem_reg_me_q;
    if (flush) begin
      state_d      = S_IDLE;
      alu_out_d    = '0;
      wd_me_d      = '0;
      rd_d         = '0;
      mem_we_me_d  = 1'b0;
      me_we_d      = 1'b0;
      mem_reg_me_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (!stall) begin
          // Default is a bubble; overridden by an ALU op or an MD_EN=0 MD op.
          alu_out_d    = '0;
          wd_me_d      = '0;
          rd_d         = '0;
          mem_we_me_d  = 1'b0;
          me_we_d      = 1'b0;
          mem_reg_me_d = 1'b0;
          if (valid && is_md) begin
            if (MD_EN) begin
              state_d = S_BUSY;
              cnt_d   = SW'(XLEN-1);
              a_d     = rs1v;
              b_d     = rs2v;
              op_d    = md_op;
              rdl_d   = rd_in;
              wel_d   = de_we;
              m_d     = md_op[2] ? b_mag : a_mag;
              p_d     = md_op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            end else begin
              rd_d    = rd_in;
              me_we_d = de_we;
            end
          end else if (valid) begin
            alu_out_d    = alu_res;
            wd_me_d      = rs2v;
            rd_d         = rd_in;
            mem_we_me_d  = mem_we;
            me_we_d      = de_we;
            mem_reg_me_d = mem_reg;
          end
        end
        S_BUSY: begin
          p_d   = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q - SW'(1);
          if (cnt_q == '0) state_d = S_DONE;
        end
        S_DONE: if (!stall) begin
          state_d      = S_IDLE;
          alu_out_d    = md_res;
          wd_me_d      = '0;
          rd_d         = rdl_q;
          mem_we_me_d  = 1'b0;
          me_we_d      = wel_q;
          mem_reg_me_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset overriding flush, stall and MD work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      p_q          <= '0;
      m_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rdl_q        <= '0;
      wel_q        <= 1'b0;
      alu_out_q    <= '0;
      wd_me_q      <= '0;
      rd_q         <= '0;
      mem_we_me_q  <= 1'b0;
      me_we_q      <= 1'b0;
      mem_reg_me_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      m_q          <= m_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rdl_q        <= rdl_d;
      wel_q        <= wel_d;
      alu_out_q    <= alu_out_d;
      wd_me_q      <= wd_me_d;
      rd_q         <= rd_d;
      mem_we_me_q  <= mem_we_me_d;
      me_we_q      <= me_we_d;
      mem_reg_me_q <= mem_reg_me_d;
    end
  end

  assign alu_out    = alu_out_q;
  assign wd_me      = wd_me_q;
  assign rd         = rd_q;
  assign mem_we_me  = mem_we_me_q;
  assign me_we      = me_we_q;
  assign mem_reg_me = mem_reg_me_q;
  assign md_busy    = (state_q != S_IDLE);

endmodule

// File: doc/exec_stage_md.md
EXEC_STAGE_MD -- requirements
Module: exec_stage_md

Interface
REQ-001 Parameter XLEN, default 32: datapath width; legal values 32 and 64.
REQ-002 Parameter MD_EN, default 1: enables the iterative multiply/divide unit; when 0, MD ops complete as single-cycle zero results.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 STALL in 1 hold EX/MEM register; FLUSH in 1 bubble EX/MEM and abort MD.
REQ-006 VALID in 1 instruction present in EX; IS_MD in 1 select MD unit over ALU.
REQ-007 ALU_CONTROL in 4 ALU op (ADD,SUB,AND,OR,XOR,SLL,SRL,SRA,SLT,SLTU); MD_OP in 3 RV M-ext funct3.
REQ-008 ALU_SRC2 in 2: 0 = RS2, 1 = ImmI, 2 = ImmS, 3 = ImmB; IMM in XLEN, pre-extended immediate.
REQ-009 D1, D2, BP_MEM, BP_WB in XLEN each; HU_RS1, HU_RS2 in 2 each, forward select 0 = D, 1 = MEM, 2 = WB.
REQ-010 RD_IN in 5; MEM_WE, DE_WE, MEM_REG in 1 each: control passed to MEM.
REQ-011 ALU_OUT, WD_ME out XLEN; RD out 5; MEM_WE_ME, ME_WE, MEM_REG_ME out 1: EX/MEM register.
REQ-012 MD_BUSY out 1: MD unit occupied; hazard unit stalls IF/ID/EX.

Function
REQ-013 RS1V/RS2V SHALL be forwarding-mux outputs; HU select 3 SHALL act as 0.
REQ-014 WD_ME SHALL capture forwarded RS2V (store data), never the ALU B operand.
REQ-015 ALU ops: single cycle; EX/MEM loads on edge when VALID & !IS_MD & !STALL & !MD_BUSY.
REQ-016 Shifts SHALL use the low log2(XLEN) bits of B; SLT signed, SLTU unsigned; add/sub wrap modulo 2^XLEN.
REQ-017 FSM states IDLE, BUSY, DONE; reset state IDLE; MD_BUSY = (state != IDLE).
REQ-018 IDLE->BUSY on VALID & IS_MD & !STALL & !FLUSH: latch RS1V, RS2V, MD_OP, RD_IN, DE_WE; counter := XLEN-1; EX/MEM loads bubble (all controls 0).
REQ-019 BUSY: one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); BUSY->DONE when counter = 0.
REQ-020 DONE: apply sign fix-up, load EX/MEM with result, ME_WE = latched DE_WE, MEM_WE_ME = MEM_REG_ME = 0; DONE->IDLE; if STALL, remain in DONE.
REQ-021 Latency: accept edge N; result visible on ALU_OUT after edge N+XLEN+1.
REQ-022 MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits with ss/su/uu signedness.
REQ-023 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend; no trap.
REQ-024 Signed overflow (-2^(XLEN-1) / -1): quotient = dividend, remainder = 0.
REQ-025 VALID inputs while MD_BUSY SHALL be ignored; the pipeline holds them upstream.
REQ-026 FLUSH outranks STALL: EX/MEM controls and data SHALL be zeroed, FSM -> IDLE, in any state.
REQ-027 STALL in IDLE SHALL hold all EX/MEM outputs unchanged.

Reset
REQ-028 On rst high at a clock edge: FSM = IDLE, counter = 0, all EX/MEM outputs = 0, MD_BUSY = 0.
REQ-029 rst SHALL override FLUSH, STALL and any in-flight MD op; no partial result appears after reset.

Verification
REQ-030 ADD, D1 = 5, IMM = -3, ALU_SRC2 = 1 -> ALU_OUT = 2 one edge later; HU_RS1 = 1, BP_MEM = 7 -> 4.
REQ-031 MUL 0xFFFFFFFF x 2 (XLEN = 32) -> MD_BUSY for 33 cycles; ALU_OUT = 0xFFFFFFFE; MULHU -> 1; MULH -> 0xFFFFFFFF.
REQ-032 DIV 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; DIV 0x80000000 / -1 -> 0x80000000; REM -> 0.
REQ-033 DIV -7 / 2 -> quotient -3; REM -> -1.
REQ-034 DIV started, FLUSH at BUSY cycle 10 -> next edge: MD_BUSY = 0, ME_WE = 0, ALU_OUT = 0.
REQ-035 rst mid-BUSY, then STALL held in DONE -> FSM = IDLE, outputs zero; with STALL in DONE, result appears on the first edge after STALL drops.
